uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Buffered transmit front-end that sits directly upstream of the UART transmitter.
- Accepts bytes from the system side through a valid/ready handshake and stores them in a circular FIFO.
- Launches one byte at a time into the transmitter using a one-cycle start pulse, then waits on the transmitter busy flag before launching the next byte.
- Lets producers burst bytes without tracking the baud-rate timing of the serial link.

Parameters:
- DATA_WIDTH, 8, width of each byte/word.
- DEPTH, 16, number of FIFO entries; must be a power of two and at least 2.
- ADDR_WIDTH, $clog2(DEPTH), read/write pointer width.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_valid  input  1  producer has a byte on wr_data.
- wr_data  input  DATA_WIDTH  byte to enqueue.
- wr_ready  output  1  FIFO can accept a byte; equals !full.
- flush  input  1  synchronous clear of queued (not in-flight) bytes.
- tx_data  output  DATA_WIDTH  byte presented to the transmitter; registered.
- tx_start  output  1  one-cycle launch pulse to the transmitter.
- tx_busy  input  1  transmitter is shifting a frame.
- count  output  ADDR_WIDTH+1  number of queued entries, 0..DEPTH; excludes the byte in flight.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky error flag.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Pointers = 0, count = 0, state = IDLE.
  - tx_start = 0, tx_data = 0, overflow = 0.
  - empty = 1, full = 0, wr_ready = 1.
  - Reset mid-frame abandons the in-flight byte; the transmitter is reset separately.
- Write:
  - Accepted on an edge where wr_valid && wr_ready.
  - Data is stored at wr_ptr; wr_ptr increments modulo DEPTH, wrapping naturally.
  - count updates in the next cycle.
- Overflow:
  - wr_valid=1 while full=1 drops the data and sets overflow.
  - overflow stays set until rst or flush.
- Read:
  - A pop happens only in state IDLE when !empty.
  - mem[rd_ptr] is loaded into the tx_data register; rd_ptr increments modulo DEPTH.
- Simultaneous write and pop in the same cycle: both take effect and count is unchanged.
  - When full, wr_ready=0, so no write occurs even if a pop happens that cycle.
- State machine:
  - IDLE: if !empty, pop and go to LAUNCH; else stay.
  - LAUNCH: tx_start=1 for exactly this cycle; tx_data is stable. Go to WAIT_ACK.
  - WAIT_ACK: wait for tx_busy=1, then go to WAIT_DONE. If tx_busy is already 1 on the first WAIT_ACK cycle, it counts immediately.
  - WAIT_DONE: wait for tx_busy=0, then go to IDLE.
- tx_data holds its value from LAUNCH until the next pop; it does not change while a frame is in flight.
- Latency:
  - Write accepted at edge N into an empty FIFO with FSM in IDLE: empty deasserts after edge N.
  - Pop at edge N+1; tx_start=1 during the cycle after edge N+1.
- Back-to-back throughput: one byte per transmitter frame plus 2 cycles (IDLE + LAUNCH).
- flush:
  - Sets rd_ptr = wr_ptr = 0, count = 0, overflow = 0 on the edge.
  - A write in the same cycle as flush is discarded.
  - The FSM is not affected: an in-flight byte completes normally.
  - flush in IDLE with pending data takes priority over the pop, so no launch occurs.
- tx_start is never asserted while the FSM is in WAIT_ACK or WAIT_DONE.

Test Plan:
- Reset, then write 0xA5 once, with tx_busy modelled as high for 10 cycles after tx_start:
  - tx_start pulses for exactly 1 cycle, 2 cycles after the write edge.
  - tx_data=0xA5.
  - count returns to 0 and empty=1.
- Burst-write 0x01..0x05 on consecutive cycles, with the transmitter model busy for 20 cycles per byte:
  - Exactly 5 tx_start pulses, carrying 0x01..0x05 in order.
  - Each pulse follows the previous tx_busy falling edge by 2 cycles.
- Hold tx_busy=1 to stall, then write 17 bytes with DEPTH=16:
  - The first byte is popped, so 16 are queued.
  - full=1, wr_ready=0, count=16.
  - The 18th write attempt sets overflow=1; the dropped byte is never transmitted.
- Wrap-around: enqueue and drain 40 sequential bytes through the DEPTH=16 FIFO.
  - Output order matches input exactly across pointer wrap.
- Queue 3 bytes, then assert flush while byte 1 is in WAIT_DONE:
  - Byte 1 finishes.
  - No further tx_start occurs.
  - count=0, overflow cleared.
- Assert rst while in WAIT_DONE with 4 bytes queued:
  - On the next cycle, count=0, tx_start=0, tx_data=0, state IDLE.
  - A subsequent write of 0x3C launches normally.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered transmit front-end for a UART transmitter.
// Bytes arrive over a valid/ready handshake and are held in a circular FIFO.
// A small controller pops one byte at a time, pulses tx_start for one cycle,
// then follows the transmitter's busy flag before launching the next byte.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_start,
    input  logic                  tx_busy,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    state_e                state_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  tx_start_q;
    logic                  full_w;
    logic                  empty_w;
    logic                  wr_en;
    logic                  pop;

    assign full_w   = (count_q == FULL_COUNT);
    assign empty_w  = (count_q == '0);
    assign full     = full_w;
    assign empty    = empty_w;
    assign wr_ready = !full_w;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;

    // A flush discards any same-cycle write and pre-empts a pop from IDLE.
    assign wr_en = wr_valid && !full_w && !flush;
    assign pop   = (state_q == IDLE) && !empty_w && !flush;

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (wr_en && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (!wr_en && pop) begin
                count_d = count_q - CNT_ONE;
            end
            if (wr_valid && full_w) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; entries are only
        // ever read after being written, so the pointers alone define validity.
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointer, occupancy and overflow registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Launch controller: pop, one-cycle start pulse, then track tx_busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        tx_data_q  <= mem_q[rd_ptr_q];
                        tx_start_q <= 1'b1;
                        state_q    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    state_q <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (tx_busy) begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
